// File: rtl/fault_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fault_gate_pkg
// Brief    : Shared types and constants for the faulty multi-input gate array:
//            evaluation modes, default LFSR seed and maximal-length tap masks.
// Revision : 1.0 - initial release
// ============================================================================
package fault_gate_pkg;

   typedef enum logic [1:0] {
      MODE_PROP = 2'b00,
      MODE_AND  = 2'b01,
      MODE_OR   = 2'b10,
      MODE_MAJ  = 2'b11
   } mode_e;

   localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

   // Right-shift Galois feedback masks; bit (t-1) is set for each tap t of a
   // primitive polynomial. Only widths 8..32 are meaningful.
   function automatic logic [31:0] lfsr_taps(input int width);
      logic [31:0] taps;
      case (width)
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_D008;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fault_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : fault_lfsr
// Brief    : Free-running right-shift Galois LFSR, reloaded with SEED on reset.
//            A nonzero seed keeps the register out of the all-zero lock state.
// Revision : 1.0 - initial release
// ============================================================================
module fault_lfsr
   import fault_gate_pkg::*;
#(
   parameter int          WIDTH = 16,
   parameter logic [31:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] state
);

   localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   // Galois step: shift right, fold the outgoing bit back through the taps
   always_comb begin
      state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
   end

   // State register; advances every cycle outside reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEED_W;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/gate_multi_fault_array.sv
`default_nettype none
// ============================================================================
// Module   : gate_multi_fault_array
// Brief    : Array of faulty multi-input gates sharing one LFSR. Each channel
//            reduces its inputs by mode and, on its fault strobe, may latch
//            its output high; emits a fire pulse and a saturating count.
// Revision : 1.0 - initial release
// ============================================================================
module gate_multi_fault_array
   import fault_gate_pkg::*;
#(
   parameter int          CHANNELS    = 4,
   parameter int          INPUT_COUNT = 2,
   parameter int          LFSR_W      = 16,
   parameter logic [31:0] SEED        = DEFAULT_SEED,
   parameter int          CNT_W       = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            logic_reset,
   input  logic [1:0]                      mode,
   input  logic [CHANNELS*INPUT_COUNT-1:0] in,
   input  logic [CHANNELS-1:0]             fault_in,
   output logic [CHANNELS-1:0]             out,
   output logic [CHANNELS-1:0]             fire_pulse,
   output logic [CHANNELS*CNT_W-1:0]       fire_count,
   output logic [LFSR_W-1:0]               lfsr_state
);

   localparam int                 ONES_W  = $clog2(INPUT_COUNT + 1);
   // Product width chosen so ones*STEP can never truncate
   localparam int                 PROD_W  = LFSR_W + ONES_W;
   localparam logic [63:0]        STEP_64 = ((64'd1 << LFSR_W) - 64'd1) / 64'(INPUT_COUNT);
   localparam logic [PROD_W-1:0]  STEP    = STEP_64[PROD_W-1:0];
   localparam logic [ONES_W-1:0]  FULL    = ONES_W'(INPUT_COUNT);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   logic [LFSR_W-1:0] lfsr_cur;

   fault_lfsr #(
      .WIDTH (LFSR_W),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .state (lfsr_cur)
   );

   assign lfsr_state = lfsr_cur;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      // Channels spread their samples around the LFSR by rotation
      localparam int ROT = (c * LFSR_W / CHANNELS) % LFSR_W;

      logic [INPUT_COUNT-1:0] bits;
      logic [LFSR_W-1:0]      r;
      logic [ONES_W-1:0]      ones;
      logic                   hit;
      logic                   set;
      logic                   out_q,   out_d;
      logic                   pulse_q, pulse_d;
      logic [CNT_W-1:0]       cnt_q,   cnt_d;

      assign bits = in[c*INPUT_COUNT +: INPUT_COUNT];

      // Random sample, popcount and mode reduction into a single hit bit
      always_comb begin
         r    = '0;
         ones = '0;
         hit  = 1'b0;
         for (int i = 0; i < LFSR_W; i++) begin
            r[(i + ROT) % LFSR_W] = lfsr_cur[i];
         end
         for (int i = 0; i < INPUT_COUNT; i++) begin
            ones = ones + ONES_W'(bits[i]);
         end
         case (mode_e'(mode))
            MODE_PROP: begin
               if (ones == '0) begin
                  hit = 1'b0;
               end else if (ones == FULL) begin
                  hit = 1'b1;
               end else begin
                  hit = (PROD_W'(r) < (PROD_W'(ones) * STEP));
               end
            end
            MODE_AND: hit = (ones == FULL);
            MODE_OR:  hit = (ones != '0);
            MODE_MAJ: hit = ({ones, 1'b0} > {1'b0, FULL});
            default:  hit = 1'b0;
         endcase
      end

      // Latch/clear decision; a same-cycle logic_reset drops any set
      always_comb begin
         set     = fault_in[c] & hit & ~out_q & ~logic_reset;
         out_d   = out_q;
         pulse_d = 1'b0;
         cnt_d   = cnt_q;
         if (logic_reset) begin
            out_d = 1'b0;
         end else if (set) begin
            out_d   = 1'b1;
            pulse_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      // Channel state registers
      always_ff @(posedge clk) begin
         if (reset) begin
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            out_q   <= out_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
         end
      end

      assign out[c]                       = out_q;
      assign fire_pulse[c]                = pulse_q;
      assign fire_count[c*CNT_W +: CNT_W] = cnt_q;
   end

endmodule
`default_nettype wire
